// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory access sequencer: FSM state encoding,
// transfer size codes and the helpers that turn a size code into a beat count
// and a big-endian byte lane.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Number of byte beats a transfer of the given size needs (11 behaves as word).
  function automatic logic [2:0] beats_for_size(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Byte lane of the 32-bit data word touched by a beat. Beat 0 carries the
  // most significant byte of the transfer, so lanes count down as beats go up.
  function automatic logic [1:0] lane_for_beat(input logic [1:0] sz,
                                               input logic [1:0] beat);
    case (sz)
      SZ_BYTE: return 2'd0;
      SZ_HALF: return 2'd1 - beat;
      default: return 2'd3 - beat;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_sequencer_beat_timer.sv
// Beat timer: counts WAIT_STATES idle cycles per beat and then advances the
// beat index. beat_done marks the cycle on which the current beat completes,
// last_beat flags that the current beat is the final one of the transfer.
module beat_timer #(
  parameter int WAIT_STATES = 2
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       start,
  input  logic       run,
  input  logic [2:0] n_beats,
  output logic [1:0] beat,
  output logic       beat_done,
  output logic       last_beat
);

  localparam int WCNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WAIT_STATES);

  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [1:0]        beat_q, beat_d;

  assign beat      = beat_q;
  assign beat_done = run && (wcnt_q == WCNT_MAX);
  assign last_beat = ({1'b0, beat_q} == (n_beats - 3'd1));

  // Next-state for the wait-state and beat counters.
  always_comb begin
    wcnt_d = wcnt_q;
    beat_d = beat_q;
    if (start) begin
      wcnt_d = '0;
      beat_d = 2'd0;
    end else if (run) begin
      if (wcnt_q == WCNT_MAX) begin
        wcnt_d = '0;
        beat_d = beat_q + 2'd1;
      end else begin
        wcnt_d = wcnt_q + WCNT_W'(1);
      end
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge Clk) begin
    if (reset) begin
      wcnt_q <= '0;
      beat_q <= 2'd0;
    end else begin
      wcnt_q <= wcnt_d;
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/memory_access_sequencer.sv
// Memory access sequencer: turns one CPU byte/halfword/word request into
// big-endian byte beats on an 8-bit RAM, with WAIT_STATES idle cycles per
// beat, and answers with the MOC handshake once the transfer is complete.
module memory_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MOC,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  state_e            state_q, state_d;
  logic              rw_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] aligned_addr;
  logic [31:0]       dout_q, dout_d;

  logic              latch;
  logic              in_access;
  logic [2:0]        n_beats;
  logic [1:0]        beat;
  logic              beat_done;
  logic              last_beat;
  logic [1:0]        lane;

  assign latch     = (state_q == IDLE) && MOV;
  assign in_access = (state_q == ACCESS);
  assign n_beats   = beats_for_size(size_q);
  assign lane      = lane_for_beat(size_q, beat);

  beat_timer #(
    .WAIT_STATES(WAIT_STATES)
  ) u_timer (
    .Clk      (Clk),
    .reset    (reset),
    .start    (latch),
    .run      (in_access),
    .n_beats  (n_beats),
    .beat     (beat),
    .beat_done(beat_done),
    .last_beat(last_beat)
  );

  // Force the request address onto its natural size boundary.
  always_comb begin
    case (size)
      SZ_BYTE: aligned_addr = addr;
      SZ_HALF: aligned_addr = {addr[ADDR_W-1:1], 1'b0};
      default: aligned_addr = {addr[ADDR_W-1:2], 2'b00};
    endcase
  end

  // FSM next state: a transfer always runs to completion, and DONE waits for
  // MOV to fall so one request can never start two transfers.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (MOV) state_d = ACCESS;
      ACCESS:  if (beat_done && last_beat) state_d = DONE;
      DONE:    if (!MOV) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data assembly: cleared at request time so narrow reads zero-extend,
  // then each completing read beat fills its own byte lane.
  always_comb begin
    dout_d = dout_q;
    if (latch && RW) begin
      dout_d = '0;
    end else if (in_access && rw_q && beat_done) begin
      dout_d[{lane, 3'b000} +: 8] = ram_rdata;
    end
  end

  // Control state and read data register; reset abandons any transfer.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= IDLE;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
    end
  end

  // Request capture: later changes on the request inputs are ignored.
  always_ff @(posedge Clk) begin
    if (latch) begin
      rw_q    <= RW;
      size_q  <= size;
      wdata_q <= DataIn;
      base_q  <= aligned_addr;
    end
  end

  // RAM side is only driven during ACCESS; the write strobe is confined to the
  // last cycle of each beat while address and data stay stable the whole beat.
  assign ram_addr  = in_access ? (base_q + ADDR_W'(beat)) : '0;
  assign ram_we    = in_access && !rw_q && beat_done;
  assign ram_wdata = (in_access && !rw_q) ? wdata_q[{lane, 3'b000} +: 8] : 8'h00;

  assign DataOut = dout_q;
  assign MOC     = (state_q == DONE);
  assign busy    = in_access;

endmodule
